// File: rtl/bcd_chain_seq.sv
// bcd_chain_seq: walks a pair of packed-BCD operands byte by byte (LSB first),
// doing a binary ADC/SBC with Game Boy flags, then a decimal adjust, and
// chaining the decimal carry/borrow into the next byte.

// gb_daa: Game Boy style decimal adjust of an 8-bit ADC/SBC result.
module gb_daa (
    input  logic [7:0] value,
    input  logic       n,
    input  logic       h,
    input  logic       c,
    output logic [7:0] result,
    output logic       c_out
);

    // After an add, correct each nibble that overflowed or exceeds 9; after a
    // subtract, undo the nibbles that borrowed. Carry is only ever set by add.
    always_comb begin
        result = value;
        c_out  = c;
        if (!n) begin
            if (c || (value > 8'h99)) begin
                result = result + 8'h60;
                c_out  = 1'b1;
            end
            if (h || (value[3:0] > 4'h9)) begin
                result = result + 8'h06;
            end
        end else begin
            if (c) begin
                result = result - 8'h60;
            end
            if (h) begin
                result = result - 8'h06;
            end
        end
    end

endmodule

module bcd_chain_seq #(
    parameter  int MAX_BYTES = 8,
    localparam int LW        = $clog2(MAX_BYTES + 1),
    localparam int IW        = $clog2(MAX_BYTES)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start_valid,
    output logic          o_start_ready,
    input  logic          i_sub,
    input  logic [LW-1:0] i_len,
    input  logic          i_carry_in,
    input  logic          i_abort,
    output logic [IW-1:0] o_rd_idx,
    input  logic [7:0]    i_a_byte,
    input  logic [7:0]    i_b_byte,
    output logic          o_wr_en,
    output logic [IW-1:0] o_wr_idx,
    output logic [7:0]    o_wr_data,
    output logic          o_done,
    output logic          o_carry_out,
    output logic          o_zero
);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        ADJ,
        DONE
    } state_t;

    localparam logic [LW-1:0] MAX_LEN = LW'(MAX_BYTES);

    state_t        state;
    state_t        state_next;

    logic          sub_q;
    logic [LW-1:0] len_q;
    logic          carry_q;
    logic [IW-1:0] idx_q;
    logic          zero_acc;
    logic [7:0]    r_q;
    logic          n_q;
    logic          h_q;
    logic          c_q;
    logic          done_q;
    logic          carry_out_q;
    logic          zero_q;

    logic          accept;
    logic [LW-1:0] len_clamped;
    logic          last_byte;
    logic [8:0]    bin_res;
    logic [4:0]    nib_res;
    logic [7:0]    daa_result;
    logic          daa_carry;
    logic          adj_zero;

    gb_daa u_daa (
        .value  (r_q),
        .n      (n_q),
        .h      (h_q),
        .c      (c_q),
        .result (daa_result),
        .c_out  (daa_carry)
    );

    assign o_start_ready = (state == IDLE) && !i_abort;
    assign accept        = i_start_valid && o_start_ready;
    assign len_clamped   = (i_len > MAX_LEN) ? MAX_LEN : i_len;
    assign last_byte     = (LW'(idx_q) == (len_q - LW'(1)));
    assign adj_zero      = zero_acc && (daa_result == 8'h00);

    assign o_rd_idx    = idx_q;
    assign o_wr_idx    = idx_q;
    assign o_wr_en     = (state == ADJ) && !i_abort;
    assign o_wr_data   = (state == ADJ) ? daa_result : 8'h00;
    assign o_done      = done_q && !i_abort;
    assign o_carry_out = carry_out_q;
    assign o_zero      = zero_q;

    // Binary ADC/SBC of the current operand bytes; the 9th bit of each
    // widened result is the carry (or borrow) out of that position.
    always_comb begin
        if (sub_q) begin
            bin_res = {1'b0, i_a_byte} - {1'b0, i_b_byte} - {8'b0, carry_q};
            nib_res = {1'b0, i_a_byte[3:0]} - {1'b0, i_b_byte[3:0]} - {4'b0, carry_q};
        end else begin
            bin_res = {1'b0, i_a_byte} + {1'b0, i_b_byte} + {8'b0, carry_q};
            nib_res = {1'b0, i_a_byte[3:0]} + {1'b0, i_b_byte[3:0]} + {4'b0, carry_q};
        end
    end

    // Next-state decode; abort overrides everything and returns to IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = (len_clamped == '0) ? DONE : ADD;
                end
            end
            ADD:     state_next = ADJ;
            ADJ:     state_next = last_byte ? DONE : ADD;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (i_abort) begin
            state_next = IDLE;
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Operation datapath: latch the request, register ADD results, chain the
    // decimal carry after each adjust, and publish final flags on the way
    // into DONE so they are stable in the done cycle and held afterwards.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sub_q       <= 1'b0;
            len_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            zero_acc    <= 1'b0;
            r_q         <= 8'h00;
            n_q         <= 1'b0;
            h_q         <= 1'b0;
            c_q         <= 1'b0;
            done_q      <= 1'b0;
            carry_out_q <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                sub_q    <= i_sub;
                len_q    <= len_clamped;
                carry_q  <= i_carry_in;
                idx_q    <= '0;
                zero_acc <= 1'b1;
                if (len_clamped == '0) begin
                    done_q      <= 1'b1;
                    carry_out_q <= i_carry_in;
                    zero_q      <= 1'b1;
                end
            end
            if ((state == ADD) && !i_abort) begin
                r_q <= bin_res[7:0];
                n_q <= sub_q;
                h_q <= nib_res[4];
                c_q <= bin_res[8];
            end
            if ((state == ADJ) && !i_abort) begin
                carry_q  <= daa_carry;
                zero_acc <= adj_zero;
                if (last_byte) begin
                    done_q      <= 1'b1;
                    carry_out_q <= daa_carry;
                    zero_q      <= adj_zero;
                end else begin
                    idx_q <= idx_q + IW'(1);
                end
            end
        end
    end

endmodule

// File: doc/bcd_chain_seq.md
# bcd_chain_seq

Multi-byte packed-BCD add/subtract sequencer wrapped around the CPU's 8-bit decimal-adjust datapath. It walks an operand pair byte by byte, least-significant byte first. For each byte it spends one cycle on a binary ADC/SBC with Game Boy flag semantics and one cycle on decimal adjustment, then writes the result byte and chains the decimal carry/borrow to the next byte. It sits beside the ALU and serves BCD helper routines and the test harness. It contains one instance of the team's DAA unit.

## Interface
- MAX_BYTES, 8, largest operand length in bytes; LW = $clog2(MAX_BYTES+1), IW = $clog2(MAX_BYTES)
- i_clk  in  1  system clock, all state on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_start_valid  in  1  request to start an operation
- o_start_ready  out  1  high only in IDLE while i_abort is low
- i_sub  in  1  0 = add, 1 = subtract; sampled at accept
- i_len  in  LW  byte count; sampled at accept; values above MAX_BYTES clamp to MAX_BYTES
- i_carry_in  in  1  initial carry/borrow; sampled at accept
- i_abort  in  1  cancel; honoured in any state
- o_rd_idx  out  IW  byte index of current operands
- i_a_byte, i_b_byte  in  8 each  operand bytes for o_rd_idx, combinational, valid same cycle
- o_wr_en  out  1  result write strobe
- o_wr_idx  out  IW  result byte index
- o_wr_data  out  8  decimal-adjusted result byte
- o_done  out  1  one-cycle completion pulse
- o_carry_out  out  1  final decimal carry/borrow, valid with o_done, held until next accept
- o_zero  out  1  1 if every written byte was 0x00, valid with o_done, held until next accept

## Operation
- States: IDLE, ADD, ADJ, DONE.
- IDLE: accept when i_start_valid & o_start_ready. At accept: latch sub, clamped len, carry <= i_carry_in, idx <= 0, zero_acc <= 1. If len == 0, go to DONE; otherwise go to ADD.
- ADD: read a = i_a_byte, b = i_b_byte at idx.
  - Add: r = a + b + carry; H = carry out of bit 3; C = carry out of bit 7.
  - Subtract: r = a - b - carry; H = borrow into bit 4; C = borrow out of bit 7.
  - Register r and F = {Z, N=sub, H, C} (Z unused by DAA), then go to ADJ.
- ADJ: feed the registered r/F into DAA.
  - Drive o_wr_en = 1, o_wr_idx = idx, o_wr_data = DAA result.
  - carry <= DAA C; zero_acc <= zero_acc & (result == 0).
  - If idx == len-1, go to DONE; else idx <= idx+1 and go to ADD.
- DONE: o_done = 1, o_carry_out = carry, o_zero = zero_acc, then go to IDLE.
- i_abort: the next state is IDLE from any state. No write or done is issued in the abort cycle; o_wr_en is gated low. In IDLE, abort blocks acceptance. Stale o_carry_out/o_zero are retained.
- o_rd_idx = idx in all states. Index arithmetic never wraps because len ≤ MAX_BYTES.

## Timing
- Reset values: state IDLE, o_start_ready 1, o_wr_en 0, o_wr_idx 0, o_wr_data 0x00, o_done 0, o_carry_out 0, o_zero 0, o_rd_idx 0.
- Reset has priority over abort and start. Reset mid-operation discards the remaining bytes with no further writes.
- Accept at edge k: byte j is written in cycle k+2j+2, and o_done pulses in cycle k+2·len+1 (len ≥ 1). For len = 0, o_done pulses in cycle k+1.
- Write strobes are never back-to-back; there is always an ADD cycle between them.
- o_start_ready is low from the accept edge until the cycle after DONE. A new request can be accepted in the first IDLE cycle, which gives a throughput of 2·len+2 cycles per operation.
- All outputs are registered except o_start_ready and the ADJ-cycle o_wr_data (DAA is combinational from registers), and o_wr_en, which is combinationally gated by i_abort.

## Test plan
- Single-byte add: len 1, sub 0, carry_in 0, a 0x99, b 0x01 → write idx0 = 0x00; o_done at accept+3; o_carry_out 1, o_zero 1.
- Half-carry add: a 0x09, b 0x09 → write 0x18, carry_out 0, zero 0.
- Multi-byte add: len 2, a {0x99,0x12}, b {0x01,0x00} (LSB first) → writes idx0 = 0x00, idx1 = 0x13; carry_out 0, zero 0; o_done at accept+5.
- Subtract with borrow: len 1, sub 1, a 0x00, b 0x01 → write 0x99, carry_out 1. Repeat with carry_in 1, a 0x50, b 0x25 → 0x24, carry_out 0.
- Boundaries: len 0 → o_done next cycle, carry_out = carry_in, zero 1, no writes. len MAX_BYTES+3 → exactly MAX_BYTES writes, indices 0..MAX_BYTES-1.
- Abort/reset: assert i_abort during the ADJ of byte 1 → no write that cycle, no o_done, IDLE next cycle. Assert i_rst during ADD → all outputs at reset values the next cycle. Start and abort together in IDLE → not accepted.
